// File: rtl/pingpong_dump_buffer.sv
// pingpong_dump_buffer: two-bank ping-pong tile buffer, transposing writer and random-access reader.
// A bank becomes readable once DEPTH words land in it; release_i hands it back to the writer.
module pingpong_dump_buffer #(
  parameter int DATA_W    = 64,
  parameter int DEPTH     = 4,
  parameter int COLS      = 2,
  parameter int PAD       = 1,
  parameter int TRANSPOSE = 1,
  parameter int ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [ADDR_W-1:0] s_addr_i,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  input  logic              release_i,
  output logic              finish_o,
  output logic              wr_err_o
);
  localparam int ROWS  = DEPTH / COLS;
  localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;

  if (2 ** ADDR_W < DEPTH + PAD) begin : g_addr_chk
    $error("ADDR_W too narrow for DEPTH+PAD");
  end

  logic [DATA_W-1:0] mem_q [2][DEPTH];
  logic [1:0]        full_q, full_d;
  logic              wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0]  wr_cnt_q, wr_cnt_d, wr_idx;
  logic [DATA_W-1:0] rd_data_q, rd_word;
  logic              rd_valid_q, finish_q, wr_err_q;
  logic              wr_fire, in_range, wr_last, rel_ok, rd_ok;

  assign s_ready_o  = !full_q[wr_sel_q];
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign finish_o   = finish_q;
  assign wr_err_o   = wr_err_q;

  always_comb begin
    wr_fire  = s_valid_i && s_ready_o;
    in_range = s_addr_i < ADDR_W'(DEPTH);
    wr_last  = wr_cnt_q == IDX_W'(DEPTH - 1);
    rel_ok   = release_i && full_q[rd_sel_q];
    rd_ok    = rd_en_i && full_q[rd_sel_q];
    wr_idx   = IDX_W'(TRANSPOSE != 0
               ? (s_addr_i % ADDR_W'(COLS)) * ADDR_W'(ROWS) + s_addr_i / ADDR_W'(COLS)
               : s_addr_i);
    // A filling write and a release never hit the same bank: one needs it empty, the other full.
    full_d   = (full_q | ((wr_fire && wr_last) ? 2'b01 << wr_sel_q : 2'b00))
               & ~(rel_ok ? 2'b01 << rd_sel_q : 2'b00);
    wr_sel_d = wr_sel_q ^ (wr_fire && wr_last);
    rd_sel_d = rd_sel_q ^ rel_ok;
    wr_cnt_d = wr_fire ? (wr_last ? '0 : wr_cnt_q + 1'b1) : wr_cnt_q;
    rd_word  = rd_addr_i < ADDR_W'(DEPTH) ? mem_q[rd_sel_q][rd_addr_i[IDX_W-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (wr_fire && in_range) mem_q[wr_sel_q][wr_idx] <= s_data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q     <= '0;
      wr_sel_q   <= 1'b0;
      rd_sel_q   <= 1'b0;
      wr_cnt_q   <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      finish_q   <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      full_q     <= full_d;
      wr_sel_q   <= wr_sel_d;
      rd_sel_q   <= rd_sel_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_data_q  <= rd_ok ? rd_word : rd_data_q;
      rd_valid_q <= rd_ok;
      finish_q   <= full_d[rd_sel_d];
      wr_err_q   <= wr_fire && !in_range;
    end
  end
endmodule
